// File: rtl/apb_master_2slave.sv
// APB3 master bridge: turns local read/write requests into SETUP/ACCESS phases
// toward two slaves (address MSB selects), with ACCESS timeout and error reporting.
module apb_master_2slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  transfer,
  input  logic                  read_write,
  input  logic [ADDR_WIDTH:0]   apb_write_paddr,
  input  logic [DATA_WIDTH-1:0] apb_write_data,
  input  logic [ADDR_WIDTH:0]   apb_read_paddr,
  output logic [DATA_WIDTH-1:0] apb_read_data_out,
  output logic                  xfer_done,
  output logic                  xfer_err,
  output logic                  busy,
  output logic                  psel1,
  output logic                  psel2,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready1,
  input  logic                  pready2,
  input  logic [DATA_WIDTH-1:0] prdata1,
  input  logic [DATA_WIDTH-1:0] prdata2,
  input  logic                  pslverr1,
  input  logic                  pslverr2
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam int              CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [1:0]            r_state;
  logic                  r_sel2;
  logic                  r_psel1;
  logic                  r_psel2;
  logic                  r_penable;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_done;
  logic                  r_err;

  logic                  w_pready;
  logic                  w_pslverr;
  logic [DATA_WIDTH-1:0] w_prdata;
  logic                  w_complete;
  logic                  w_timeout;
  logic                  w_capture;
  logic [ADDR_WIDTH:0]   w_req_addr;

  // Only the captured slave's response is observed; the other one is ignored.
  assign w_pready   = r_sel2 ? pready2  : pready1;
  assign w_pslverr  = r_sel2 ? pslverr2 : pslverr1;
  assign w_prdata   = r_sel2 ? prdata2  : prdata1;

  assign w_complete = (r_state == S_ACCESS) && w_pready;
  assign w_timeout  = (r_state == S_ACCESS) && !w_pready && (r_cnt == CNT_MAX);
  // A new request is taken from IDLE or on the completion edge (back-to-back), never on abort.
  assign w_capture  = transfer && ((r_state == S_IDLE) || w_complete);
  assign w_req_addr = read_write ? apb_read_paddr : apb_write_paddr;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= S_IDLE;
      r_sel2    <= 1'b0;
      r_psel1   <= 1'b0;
      r_psel2   <= 1'b0;
      r_penable <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= w_complete && !w_pslverr;
      r_err  <= (w_complete && w_pslverr) || w_timeout;
      if (w_complete && !w_pslverr && !r_write) begin
        r_rdata <= w_prdata;
      end

      if (w_capture) begin
        r_state   <= S_SETUP;
        r_sel2    <= w_req_addr[ADDR_WIDTH];
        r_psel1   <= !w_req_addr[ADDR_WIDTH];
        r_psel2   <= w_req_addr[ADDR_WIDTH];
        r_penable <= 1'b0;
        r_write   <= !read_write;
        r_addr    <= w_req_addr[ADDR_WIDTH-1:0];
        r_wdata   <= read_write ? '0 : apb_write_data;
        r_cnt     <= '0;
      end else if (r_state == S_SETUP) begin
        r_state   <= S_ACCESS;
        r_penable <= 1'b1;
      end else if (w_complete || w_timeout) begin
        r_state   <= S_IDLE;
        r_psel1   <= 1'b0;
        r_psel2   <= 1'b0;
        r_penable <= 1'b0;
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign busy              = (r_state != S_IDLE);
  assign psel1             = r_psel1;
  assign psel2             = r_psel2;
  assign penable           = r_penable;
  assign pwrite            = r_write;
  assign paddr             = r_addr;
  assign pwdata            = r_wdata;
  assign apb_read_data_out = r_rdata;
  assign xfer_done         = r_done;
  assign xfer_err          = r_err;

endmodule
